// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, default widths and the boot preset table for
// the parametrised integer register file.
//   state_t     - sequencer state (ST_INIT, ST_READY)
//   preset_val  - boot constant for a register index (0 for unlisted indices)
package regfile_pkg;

    localparam int DEF_DW     = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 2;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // The INIT sequencer only visits indices 1..DEPTH-1, so entries at or
    // above DEPTH are never requested and drop out for small files.
    function automatic logic [31:0] preset_val(input logic [31:0] idx);
        logic [31:0] val;
        case (idx)
            32'd1:   val = 32'd150;
            32'd2:   val = 32'd999;
            32'd3:   val = 32'd2;
            32'd4:   val = 32'd10;
            32'd5:   val = 32'd11;
            32'd11:  val = 32'd109;
            32'd15:  val = 32'd100;
            default: val = 32'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/regfile_param_if.sv
// regfile_param_if: read, write and busy-set bus of the register file.
//   master - decode/writeback/load-divide side (drives addresses and strobes)
//   slave  - register file side (drives init_done, rd_data, rd_busy)
interface regfile_param_if #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
);
    logic                 init_done;
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    rd_busy;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic                 busy_set;
    logic [AW-1:0]        busy_addr;

    modport master (
        input  init_done, rd_data, rd_busy,
        output rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr
    );

    modport slave (
        output init_done, rd_data, rd_busy,
        input  rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: DEPTH-bit pending-write vector.
//   clk, reset          - core clock, async active-low reset
//   set_en/set_addr     - mark a register pending (wins over a same-edge clear)
//   clr_en/clr_addr     - clear pending on writeback
//   rd_addr/rd_busy     - per-read-port busy lookup (raw, not gated by INIT)
module regfile_scoreboard #(
    parameter  int DEPTH  = 32,
    parameter  int NUM_RD = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_en,
    input  logic [AW-1:0]        set_addr,
    input  logic                 clr_en,
    input  logic [AW-1:0]        clr_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy
);

    logic [DEPTH-1:0] busy;

    // Set is applied after clear so a write-after-write reissue keeps the
    // register pending. x0 can never become pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_addr] <= 1'b0;
            if (set_en && (set_addr != '0)) busy[set_addr] <= 1'b1;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy[k] = busy[rd_addr[k*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised integer register file with boot preset loader
// and per-register busy scoreboard.
//   clk    - core clock
//   reset  - async active-low reset
//   bus    - regfile_param_if.slave: init_done, NUM_RD read ports with busy,
//            one write port, one busy-set port
// Optional build macro REGFILE_BYPASS_EN: forward a same-cycle write to
// matching read ports (busy reflects the write unless a same-cycle busy_set
// targets the same register).
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic            clk,
    input  logic            reset,
    regfile_param_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    state_t               state;
    logic [AW-1:0]        idx;
    logic                 init_done_q;
    logic [DW-1:0]        regs [DEPTH];
    logic                 ready;
    logic                 wr_ok;
    logic                 set_ok;
    logic [NUM_RD-1:0]    sb_busy;
    logic [NUM_RD*DW-1:0] rd_data_c;
    logic [NUM_RD-1:0]    rd_busy_c;

    assign ready  = (state == ST_READY);
    assign wr_ok  = ready && bus.wr_en && (bus.wr_addr != '0);
    assign set_ok = ready && bus.busy_set && (bus.busy_addr != '0);

    // regs[0] is cleared on reset and never written afterwards, so reads of
    // x0 fall out as zero without a special case.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_INIT;
            idx         <= AW'(1);
            init_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ST_INIT: begin
                    regs[idx] <= DW'(preset_val(32'(idx)));
                    idx       <= idx + AW'(1);
                    if (idx == AW'(DEPTH - 1)) begin
                        state       <= ST_READY;
                        init_done_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (set_ok),
        .set_addr (bus.busy_addr),
        .clr_en   (wr_ok),
        .clr_addr (bus.wr_addr),
        .rd_addr  (bus.rd_addr),
        .rd_busy  (sb_busy)
    );

    // Reads are blanked while the preset table is loading.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (ready) begin
                rd_data_c[k*DW +: DW] = regs[bus.rd_addr[k*AW +: AW]];
                rd_busy_c[k]          = sb_busy[k];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (bus.wr_addr == bus.rd_addr[k*AW +: AW])) begin
                    rd_data_c[k*DW +: DW] = bus.wr_data;
                    rd_busy_c[k]          = set_ok && (bus.busy_addr == bus.wr_addr);
                end
`endif
            end
        end
    end

    assign bus.init_done = init_done_q;
    assign bus.rd_data   = rd_data_c;
    assign bus.rd_busy   = rd_busy_c;

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;

    regfile_param_if #(.DW(32), .AW(5), .NUM_RD(2)) bus ();

    regfile_param #(.DW(32), .DEPTH(32), .NUM_RD(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rd(input string tag, input int port, input logic [31:0] d, input logic b);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.data = d;
        e.busy = b;
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, "_data"}, bus.rd_data[e.port*32 +: 32], e.data);
            chk({e.tag, "_busy"}, {31'd0, bus.rd_busy[e.port]}, {31'd0, e.busy});
        end
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now();
        @(negedge clk);
        drain();
    endtask

    // Releases reset and counts edges until init_done, holding a write and a
    // busy_set that must be ignored while the preset table loads.
    task automatic wait_init(input string tag);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        reset         = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 5'd5;
        bus.wr_data   = 32'hDEAD;
        bus.busy_set  = 1'b1;
        bus.busy_addr = 5'd5;
        set_rd(5'd1, 5'd1);
        while (n < 100 && !done) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.init_done) begin
                done = 1'b1;
            end else if (n == 3) begin
                push_rd({tag, "_rd_in_init"}, 0, 32'd0, 1'b0);
                check_now();
            end
        end
        bus.wr_en    = 1'b0;
        bus.busy_set = 1'b0;
        chk({tag, "_len"}, 32'(n), 32'd31);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b0;
        bus.rd_addr   = '0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.busy_set  = 1'b0;
        bus.busy_addr = '0;
        set_rd(5'd1, 5'd2);

        @(negedge clk);
        chk("rst_init_done", {31'd0, bus.init_done}, 32'd0);
        push_rd("rst_p0", 0, 32'd0, 1'b0);
        push_rd("rst_p1", 1, 32'd0, 1'b0);
        drain();

        next_cyc();
        wait_init("init1");

        set_rd(5'd1, 5'd2);
        push_rd("x1", 0, 32'd150, 1'b0);
        push_rd("x2", 1, 32'd999, 1'b0);
        check_now();

        next_cyc();
        set_rd(5'd15, 5'd6);
        push_rd("x15", 0, 32'd100, 1'b0);
        push_rd("x6", 1, 32'd0, 1'b0);
        check_now();

        next_cyc();
        set_rd(5'd5, 5'd0);
        push_rd("x5_after_init", 0, 32'd11, 1'b0);
        push_rd("x0", 1, 32'd0, 1'b0);
        check_now();

        // write x7
        next_cyc();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h1234;
        set_rd(5'd7, 5'd7);
        push_rd("x7_same", 0, BYP ? 32'h1234 : 32'd0, 1'b0);
        check_now();
        next_cyc();
        bus.wr_en = 1'b0;
        push_rd("x7_next", 0, 32'h1234, 1'b0);
        check_now();

        // write x0 is discarded
        next_cyc();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF_FFFF;
        set_rd(5'd0, 5'd7);
        push_rd("x0_wr_same", 0, 32'd0, 1'b0);
        push_rd("x7_keep", 1, 32'h1234, 1'b0);
        check_now();
        next_cyc();
        bus.wr_en = 1'b0;
        push_rd("x0_wr_next", 0, 32'd0, 1'b0);
        check_now();

        // busy_set x9, write two cycles later
        next_cyc();
        bus.busy_set = 1'b1; bus.busy_addr = 5'd9;
        set_rd(5'd9, 5'd0);
        push_rd("x9_set_same", 0, 32'd0, 1'b0);
        check_now();
        next_cyc();
        bus.busy_set = 1'b0;
        push_rd("x9_busy1", 0, 32'd0, 1'b1);
        check_now();
        next_cyc();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'd42;
        push_rd("x9_wr_same", 0, BYP ? 32'd42 : 32'd0, BYP ? 1'b0 : 1'b1);
        check_now();
        next_cyc();
        bus.wr_en = 1'b0;
        push_rd("x9_wr_next", 0, 32'd42, 1'b0);
        check_now();

        // same-cycle busy_set and write: set wins
        next_cyc();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'd43;
        bus.busy_set = 1'b1; bus.busy_addr = 5'd9;
        push_rd("x9_both_same", 0, BYP ? 32'd43 : 32'd42, BYP ? 1'b1 : 1'b0);
        check_now();
        next_cyc();
        bus.wr_en = 1'b0; bus.busy_set = 1'b0;
        push_rd("x9_both_next", 0, 32'd43, 1'b1);
        check_now();

        // busy_set to x0 discarded
        next_cyc();
        bus.busy_set = 1'b1; bus.busy_addr = 5'd0;
        next_cyc();
        bus.busy_set = 1'b0;
        set_rd(5'd0, 5'd9);
        push_rd("x0_busy", 0, 32'd0, 1'b0);
        push_rd("x9_still", 1, 32'd43, 1'b1);
        check_now();

        // two ports reading a register being written
        next_cyc();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd8; bus.wr_data = 32'd77;
        set_rd(5'd8, 5'd8);
        push_rd("x8_p0_same", 0, BYP ? 32'd77 : 32'd0, 1'b0);
        push_rd("x8_p1_same", 1, BYP ? 32'd77 : 32'd0, 1'b0);
        check_now();
        next_cyc();
        bus.wr_en = 1'b0;
        push_rd("x8_p0_next", 0, 32'd77, 1'b0);
        push_rd("x8_p1_next", 1, 32'd77, 1'b0);
        check_now();

        // x3 overwrite, then reset in READY
        next_cyc();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'd5;
        next_cyc();
        bus.wr_en = 1'b0;
        set_rd(5'd3, 5'd7);
        push_rd("x3_wr", 0, 32'd5, 1'b0);
        push_rd("x7_before_rst", 1, 32'h1234, 1'b0);
        check_now();

        next_cyc();
        reset = 1'b0;
        #1;
        chk("rst_ready_async", {31'd0, bus.init_done}, 32'd0);
        push_rd("x3_in_rst", 0, 32'd0, 1'b0);
        drain();

        // release, then pulse reset again mid-INIT
        next_cyc();
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_init", {31'd0, bus.init_done}, 32'd0);
        next_cyc();
        wait_init("init2");

        set_rd(5'd3, 5'd7);
        push_rd("x3_preset_again", 0, 32'd2, 1'b0);
        push_rd("x7_cleared", 1, 32'd0, 1'b0);
        check_now();
        next_cyc();
        set_rd(5'd9, 5'd5);
        push_rd("x9_busy_cleared", 0, 32'd0, 1'b0);
        push_rd("x5_again", 1, 32'd11, 1'b0);
        check_now();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
